// File: rtl/id_regfile_stage.sv
// id_regfile_stage: MIPS register file with bypass-selected reads and an ID/EX operand latch
// ports: clk, rst_n (async active-low); wb_we/wb_waddr/wb_wdata write port;
//   id_valid/id_rs/id_rt ID request; byp_a/byp_b/byp_data_a/byp_data_b same-cycle WB bypass;
//   ex_hold/id_bubble/flush pipeline control; ex_valid/ex_rs/ex_rt/ex_a/ex_b latched ID/EX outputs
module id_regfile_stage #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          byp_a,
  input  logic          byp_b,
  input  logic [DW-1:0] byp_data_a,
  input  logic [DW-1:0] byp_data_b,
  input  logic          ex_hold,
  input  logic          id_bubble,
  input  logic          flush,
  output logic          ex_valid,
  output logic [AW-1:0] ex_rs,
  output logic [AW-1:0] ex_rt,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b
);
  localparam bit ZR = (ZERO_REG != 0);
  logic [DW-1:0] rf_q [0:(1<<AW)-1];
  logic          ex_valid_q, ex_valid_d;
  logic [AW-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic [DW-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
  logic [DW-1:0] rd_a, rd_b;
  logic          we, clr, ref_a, ref_b;
  always_comb begin
    we    = wb_we && !(ZR && wb_waddr == '0);
    rd_a  = (ZR && id_rs == '0) ? '0 : byp_a ? byp_data_a : rf_q[id_rs];
    rd_b  = (ZR && id_rt == '0) ? '0 : byp_b ? byp_data_b : rf_q[id_rt];
    // bubble only applies when EX is free to accept; flush always squashes
    clr   = flush || (!ex_hold && id_bubble);
    // a held instruction must not miss a result written back while it waits
    ref_a = ex_valid_q && wb_we && wb_waddr == ex_rs_q && !(ZR && ex_rs_q == '0);
    ref_b = ex_valid_q && wb_we && wb_waddr == ex_rt_q && !(ZR && ex_rt_q == '0);
    ex_valid_d = clr ? 1'b0 : ex_hold ? ex_valid_q : id_valid;
    ex_rs_d    = clr ? '0 : ex_hold ? ex_rs_q : id_rs;
    ex_rt_d    = clr ? '0 : ex_hold ? ex_rt_q : id_rt;
    ex_a_d     = clr ? '0 : ex_hold ? (ref_a ? wb_wdata : ex_a_q) : rd_a;
    ex_b_d     = clr ? '0 : ex_hold ? (ref_b ? wb_wdata : ex_b_q) : rd_b;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < (1 << AW); i++) rf_q[i] <= '0;
    else if (we)
      rf_q[wb_waddr] <= wb_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
    end
  assign ex_valid = ex_valid_q;
  assign ex_rs    = ex_rs_q;
  assign ex_rt    = ex_rt_q;
  assign ex_a     = ex_a_q;
  assign ex_b     = ex_b_q;
endmodule

// File: tb/tb_id_regfile_stage.sv
// tb_id_regfile_stage: directed self-checking bench for id_regfile_stage
module tb_id_regfile_stage;
  logic        clk = 0, rst_n = 0;
  logic        wb_we, id_valid, byp_a, byp_b, ex_hold, id_bubble, flush;
  logic [4:0]  wb_waddr, id_rs, id_rt;
  logic [31:0] wb_wdata, byp_data_a, byp_data_b;
  logic        ex_valid;
  logic [4:0]  ex_rs, ex_rt;
  logic [31:0] ex_a, ex_b;
  int passed = 0, total = 0;
  id_regfile_stage #(.DW(32), .AW(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .byp_a(byp_a), .byp_b(byp_b),
    .byp_data_a(byp_data_a), .byp_data_b(byp_data_b), .ex_hold(ex_hold),
    .id_bubble(id_bubble), .flush(flush), .ex_valid(ex_valid), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_a(ex_a), .ex_b(ex_b));
  always #5 clk = ~clk;
  task automatic idle();
    wb_we = 0; wb_waddr = 0; wb_wdata = 0; id_valid = 0; id_rs = 0; id_rt = 0;
    byp_a = 0; byp_b = 0; byp_data_a = 0; byp_data_b = 0;
    ex_hold = 0; id_bubble = 0; flush = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    idle();
    wb_we = 1; wb_waddr = a; wb_wdata = d;
    step();
    idle();
  endtask
  task automatic test_reset();
    idle();
    rst_n = 0;
    #12;
    total++; if ({ex_valid, ex_rs, ex_rt, ex_a, ex_b} !== '0) $display("FAIL reset_outputs: got v=%b rs=%0d rt=%0d a=%h b=%h exp all 0", ex_valid, ex_rs, ex_rt, ex_a, ex_b); else passed++;
    @(negedge clk);
    rst_n = 1;
    id_valid = 1; id_rs = 5; id_rt = 6;
    step();
    total++; if (ex_valid !== 1'b1) $display("FAIL load_valid: got %b exp 1", ex_valid); else passed++;
    total++; if (ex_rs !== 5'd5 || ex_rt !== 5'd6) $display("FAIL load_addr: got rs=%0d rt=%0d exp 5 6", ex_rs, ex_rt); else passed++;
    total++; if (ex_a !== 32'h0 || ex_b !== 32'h0) $display("FAIL load_zero_ops: got a=%h b=%h exp 0 0", ex_a, ex_b); else passed++;
    idle();
    step();
    total++; if (ex_valid !== 1'b0) $display("FAIL load_invalid: got %b exp 0", ex_valid); else passed++;
  endtask
  task automatic test_bypass();
    idle();
    wb_we = 1; wb_waddr = 5; wb_wdata = 32'hDEADBEEF;
    id_valid = 1; id_rs = 5; id_rt = 6; byp_a = 1; byp_data_a = 32'hDEADBEEF;
    step();
    total++; if (ex_a !== 32'hDEADBEEF) $display("FAIL bypass_a: got %h exp deadbeef", ex_a); else passed++;
    total++; if (ex_b !== 32'h0) $display("FAIL bypass_b_old: got %h exp 0", ex_b); else passed++;
    idle();
    id_valid = 1; id_rs = 5; id_rt = 5;
    step();
    total++; if (ex_a !== 32'hDEADBEEF) $display("FAIL array_read_a: got %h exp deadbeef", ex_a); else passed++;
    total++; if (ex_b !== 32'hDEADBEEF) $display("FAIL same_rs_rt_b: got %h exp deadbeef", ex_b); else passed++;
    wr(9, 32'hA5A5_0009);
    id_valid = 1; id_rs = 5; id_rt = 9; byp_b = 1; byp_data_b = 32'h0BAD_F00D;
    step();
    total++; if (ex_b !== 32'h0BAD_F00D) $display("FAIL bypass_b: got %h exp 0badf00d", ex_b); else passed++;
    idle();
    id_valid = 1; id_rs = 9; id_rt = 9;
    step();
    total++; if (ex_a !== 32'hA5A5_0009 || ex_b !== 32'hA5A5_0009) $display("FAIL array_read_r9: got a=%h b=%h exp a5a50009", ex_a, ex_b); else passed++;
  endtask
  task automatic test_zero_reg();
    idle();
    wb_we = 1; wb_waddr = 0; wb_wdata = 32'h1234;
    id_valid = 1; id_rs = 0; id_rt = 0; byp_a = 1; byp_data_a = 32'h1234; byp_b = 1; byp_data_b = 32'h1234;
    step();
    total++; if (ex_a !== 32'h0 || ex_b !== 32'h0) $display("FAIL zero_bypass: got a=%h b=%h exp 0 0", ex_a, ex_b); else passed++;
    idle();
    id_valid = 1; id_rs = 0; id_rt = 0;
    step();
    total++; if (ex_a !== 32'h0 || ex_b !== 32'h0) $display("FAIL zero_read: got a=%h b=%h exp 0 0", ex_a, ex_b); else passed++;
  endtask
  task automatic test_hold_refresh();
    wr(7, 32'h11);
    wr(8, 32'h33);
    id_valid = 1; id_rs = 7; id_rt = 8;
    step();
    total++; if (ex_a !== 32'h11 || ex_b !== 32'h33) $display("FAIL hold_setup: got a=%h b=%h exp 11 33", ex_a, ex_b); else passed++;
    idle();
    ex_hold = 1; id_valid = 1; id_rs = 2; id_rt = 3;
    wb_we = 1; wb_waddr = 4; wb_wdata = 32'h99;
    step();
    total++; if (ex_a !== 32'h11 || ex_b !== 32'h33 || ex_rs !== 5'd7 || ex_rt !== 5'd8) $display("FAIL hold_keep: got a=%h b=%h rs=%0d rt=%0d exp 11 33 7 8", ex_a, ex_b, ex_rs, ex_rt); else passed++;
    wb_waddr = 7; wb_wdata = 32'h22;
    step();
    total++; if (ex_a !== 32'h22 || ex_b !== 32'h33) $display("FAIL hold_refresh_a: got a=%h b=%h exp 22 33", ex_a, ex_b); else passed++;
    wb_waddr = 8; wb_wdata = 32'h44; id_bubble = 1;
    step();
    total++; if (ex_a !== 32'h22 || ex_b !== 32'h44) $display("FAIL hold_refresh_b: got a=%h b=%h exp 22 44", ex_a, ex_b); else passed++;
    total++; if (ex_valid !== 1'b1 || ex_rs !== 5'd7) $display("FAIL hold_over_bubble: got v=%b rs=%0d exp 1 7", ex_valid, ex_rs); else passed++;
    idle();
  endtask
  task automatic test_flush();
    idle();
    id_valid = 1; id_rs = 9; id_rt = 9;
    step();
    idle();
    flush = 1; ex_hold = 1; wb_we = 1; wb_waddr = 3; wb_wdata = 32'h55;
    id_valid = 1; id_rs = 9; id_rt = 9;
    step();
    total++; if (ex_valid !== 1'b0 || ex_a !== 32'h0 || ex_b !== 32'h0 || ex_rs !== 5'd0) $display("FAIL flush_clear: got v=%b a=%h b=%h rs=%0d exp 0", ex_valid, ex_a, ex_b, ex_rs); else passed++;
    idle();
    id_valid = 1; id_rs = 3; id_rt = 9;
    step();
    total++; if (ex_a !== 32'h55) $display("FAIL flush_write_kept: got %h exp 55", ex_a); else passed++;
  endtask
  task automatic test_bubble_and_async_reset();
    idle();
    id_bubble = 1; id_valid = 1; id_rs = 3; id_rt = 9;
    step();
    total++; if ({ex_valid, ex_rs, ex_rt, ex_a, ex_b} !== '0) $display("FAIL bubble_clear: got v=%b rs=%0d rt=%0d a=%h b=%h exp all 0", ex_valid, ex_rs, ex_rt, ex_a, ex_b); else passed++;
    idle();
    id_valid = 1; id_rs = 3; id_rt = 9;
    step();
    idle();
    ex_hold = 1;
    step();
    #2;
    rst_n = 0;
    #1;
    total++; if ({ex_valid, ex_rs, ex_rt, ex_a, ex_b} !== '0) $display("FAIL async_reset: got v=%b rs=%0d rt=%0d a=%h b=%h exp all 0", ex_valid, ex_rs, ex_rt, ex_a, ex_b); else passed++;
    @(negedge clk);
    rst_n = 1;
    idle();
    id_valid = 1; id_rs = 3; id_rt = 9;
    step();
    total++; if (ex_a !== 32'h0 || ex_b !== 32'h0) $display("FAIL reset_clears_array: got a=%h b=%h exp 0 0", ex_a, ex_b); else passed++;
  endtask
  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_hold_refresh();
    test_flush();
    test_bubble_and_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
